// File: rtl/ifetch_unit_if.sv
// Fetch-stage bundle: decode/ALU controls in, ROM address/data, and the instruction presented to decode.
interface ifetch_unit_if #(
    parameter int IMEM_AW = 14
) ();
    logic               stall;
    logic               branch;
    logic               zero;
    logic               jal;
    logic               jalr;
    logic [31:0]        imm32;
    logic [31:0]        alu_result;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        inst;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
    logic               inst_valid;
    logic               fault;

    modport master (
        input  stall, branch, zero, jal, jalr, imm32, alu_result, imem_rdata,
        output imem_addr, inst, pc, pc_plus4, inst_valid, fault
    );

    modport slave (
        output stall, branch, zero, jal, jalr, imm32, alu_result, imem_rdata,
        input  imem_addr, inst, pc, pc_plus4, inst_valid, fault
    );
endinterface

// File: rtl/ifetch_unit.sv
// Multi-cycle fetch: FETCH -> WAIT (IMEM_LAT cycles) -> EXEC, so IMEM_LAT+2 cycles per instruction.
// stall holds EXEC with inst/pc frozen; a misaligned next PC parks the unit in HALT until reset.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14,
    parameter int          IMEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_unit_if.master bus
);
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [1:0]  LAST_CNT = 2'(IMEM_LAT - 1);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4;
    logic [31:0] rel_target;
    logic [31:0] next_pc;
    logic        unused_alu_bit0;

    assign unused_alu_bit0 = bus.alu_result[0];

    // jalr beats jal beats taken branch; jalr target always has bit 0 cleared.
    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        rel_target = pc_q + bus.imm32;
        if (bus.jalr) begin
            next_pc = {bus.alu_result[31:1], 1'b0};
        end else if (bus.jal || (bus.branch && bus.zero)) begin
            next_pc = rel_target;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        unique case (state_q)
            S_FETCH: begin
                cnt_d   = 2'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    inst_d  = bus.imem_rdata;
                    cnt_d   = 2'd0;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_EXEC: begin
                if (!bus.stall) begin
                    if (next_pc[1]) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= 2'd0;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    // Word address aliases: PC bits above the ROM range are dropped.
    assign bus.imem_addr  = pc_q[IMEM_AW+1:2];
    assign bus.inst       = inst_q;
    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.inst_valid = (state_q == S_EXEC);
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// Two fetch units (ROM latency 1 and 3) share stimulus; a per-unit countdown model predicts every output each cycle.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, branch = 1'b0, zero = 1'b0, jal = 1'b0, jalr = 1'b0;
    logic [31:0] imm32 = 32'd0, alu_result = 32'd0;
    int          assert_cnt = 0;
    int          fail_cnt = 0;
    logic        started = 1'b0;

    always #5 clk = ~clk;

    ifetch_unit_if #(.IMEM_AW(14)) if0 ();
    ifetch_unit_if #(.IMEM_AW(14)) if1 ();

    assign if0.stall = stall;   assign if1.stall = stall;
    assign if0.branch = branch; assign if1.branch = branch;
    assign if0.zero = zero;     assign if1.zero = zero;
    assign if0.jal = jal;       assign if1.jal = jal;
    assign if0.jalr = jalr;     assign if1.jalr = jalr;
    assign if0.imm32 = imm32;   assign if1.imm32 = imm32;
    assign if0.alu_result = alu_result;
    assign if1.alu_result = alu_result;

    ifetch_unit #(.RESET_PC(32'h0), .IMEM_AW(14), .IMEM_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    ifetch_unit #(.RESET_PC(32'h0), .IMEM_AW(14), .IMEM_LAT(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    function automatic logic [31:0] rom_word(input logic [13:0] a);
        return ({18'd0, a} * 32'h9E37_79B1) ^ 32'hA5A5_0000 ^ {18'd0, a};
    endfunction

    // Synchronous ROMs with 1 and 3 cycles of read latency.
    logic [31:0] rp0, rp1[3];
    always @(posedge clk) begin
        rp0    <= rom_word(if0.imem_addr);
        rp1[0] <= rom_word(if1.imem_addr);
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
    end
    assign if0.imem_rdata = rp0;
    assign if1.imem_rdata = rp1[2];

    logic [31:0] o_pc[2], o_inst[2], o_p4[2];
    logic [13:0] o_addr[2];
    logic        o_vld[2], o_flt[2];
    assign o_pc[0] = if0.pc;         assign o_pc[1] = if1.pc;
    assign o_inst[0] = if0.inst;     assign o_inst[1] = if1.inst;
    assign o_p4[0] = if0.pc_plus4;   assign o_p4[1] = if1.pc_plus4;
    assign o_addr[0] = if0.imem_addr; assign o_addr[1] = if1.imem_addr;
    assign o_vld[0] = if0.inst_valid; assign o_vld[1] = if1.inst_valid;
    assign o_flt[0] = if0.fault;     assign o_flt[1] = if1.fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pc, last fetched word, and how many idle cycles remain before the next EXEC.
    logic [31:0] m_pc[2], m_inst[2];
    logic        m_valid[2], m_fault[2];
    int          m_wait[2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] p);
        if (jalr) return {alu_result[31:1], 1'b0};
        if (jal) return p + imm32;
        if (branch && zero) return p + imm32;
        return p + 32'd4;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_pc[i] <= 32'h0;
                m_inst[i] <= 32'h0000_0013;
                m_valid[i] <= 1'b0;
                m_fault[i] <= 1'b0;
                m_wait[i] <= lat_of(i) + 1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_fault[i]) begin
                    m_valid[i] <= 1'b0;
                end else if (!m_valid[i]) begin
                    if (m_wait[i] == 1) begin
                        m_valid[i] <= 1'b1;
                        m_inst[i] <= rom_word(m_pc[i][15:2]);
                    end
                    m_wait[i] <= m_wait[i] - 1;
                end else if (!stall) begin
                    m_valid[i] <= 1'b0;
                    m_wait[i] <= lat_of(i) + 1;
                    if ((model_target(m_pc[i]) & 32'd2) != 32'd0) m_fault[i] <= 1'b1;
                    else m_pc[i] <= model_target(m_pc[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("pc[%0d]", i), o_pc[i], m_pc[i]);
                check($sformatf("inst[%0d]", i), o_inst[i], m_inst[i]);
                check($sformatf("inst_valid[%0d]", i), {31'd0, o_vld[i]}, {31'd0, m_valid[i]});
                check($sformatf("fault[%0d]", i), {31'd0, o_flt[i]}, {31'd0, m_fault[i]});
                check($sformatf("pc_plus4[%0d]", i), o_p4[i], m_pc[i] + 32'd4);
                check($sformatf("imem_addr[%0d]", i), {18'd0, o_addr[i]}, {18'd0, m_pc[i][15:2]});
            end
        end
    end

    task automatic wait_valid(input int idx);
        int n;
        n = 0;
        while (!o_vld[idx] && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("exec_reached", {31'd0, o_vld[idx]}, 32'd1);
    endtask

    task automatic next_exec(input int idx, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_vld[idx] && n < 64);
    endtask

    task automatic step(input logic j, input logic jr, input logic b, input logic z,
                        input logic [31:0] imm, input logic [31:0] alu);
        jal = j; jalr = jr; branch = b; zero = z; imm32 = imm; alu_result = alu;
        @(negedge clk);
        jal = 0; jalr = 0; branch = 0; zero = 0; imm32 = 0; alu_result = 0;
        wait_valid(0);
    endtask

    initial begin
        int n, t0, t1;
        logic [31:0] held;
        // Reset and first-instruction latency.
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", o_pc[0], 32'h0);
        check("rst_inst", o_inst[0], 32'h0000_0013);
        check("rst_valid", {31'd0, o_vld[0]}, 32'd0);
        rst = 0;
        n = 1;
        while (!o_vld[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("first_valid_cycle", n, 3);
        check("seq_pc0", o_pc[0], 32'h0);
        check("seq_inst0", o_inst[0], rom_word(14'd0));
        for (int k = 1; k < 4; k++) begin
            next_exec(0, n);
            check("seq_cycles_lat1", n, 3);
            check("seq_pc", o_pc[0], 32'(4 * k));
            check("seq_inst", o_inst[0], rom_word(14'(k)));
        end
        // Now at pc 0x10: jump to 0x40, then branch taken / not taken.
        next_exec(0, n);
        check("pc_0x10", o_pc[0], 32'h10);
        step(1, 0, 0, 0, 32'h30, 0);
        check("jal_to_0x40", o_pc[0], 32'h40);
        step(0, 0, 1, 1, 32'hFFFF_FFF8, 0);
        check("beq_taken", o_pc[0], 32'h38);
        step(1, 0, 0, 0, 32'h8, 0);
        check("jal_back", o_pc[0], 32'h40);
        step(0, 0, 1, 0, 32'hFFFF_FFF8, 0);
        check("beq_not_taken", o_pc[0], 32'h44);
        check("pc_plus4_exec", o_p4[0], 32'h48);
        step(1, 1, 0, 0, 32'h200, 32'h0000_0101);
        check("jalr_wins", o_pc[0], 32'h100);
        // Stall holds everything.
        stall = 1;
        held = o_inst[0];
        repeat (5) begin
            @(negedge clk);
            check("stall_pc", o_pc[0], 32'h100);
            check("stall_inst", o_inst[0], held);
            check("stall_valid", {31'd0, o_vld[0]}, 32'd1);
        end
        stall = 0;
        @(negedge clk);
        check("stall_release_valid", {31'd0, o_vld[0]}, 32'd0);
        wait_valid(0);
        check("after_stall_pc", o_pc[0], 32'h104);
        // Wrap-around through the top of the address space.
        step(0, 1, 0, 0, 0, 32'hFFFF_FFFD);
        check("top_pc", o_pc[0], 32'hFFFF_FFFC);
        check("top_addr", {18'd0, o_addr[0]}, 32'h3FFF);
        check("top_plus4", o_p4[0], 32'h0);
        step(0, 0, 0, 0, 0, 0);
        check("wrap_pc", o_pc[0], 32'h0);
        step(1, 0, 0, 0, 32'h20, 0);
        stall = 1;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rst_mid_stall_pc", o_pc[0], 32'h0);
        check("rst_mid_stall_valid", {31'd0, o_vld[0]}, 32'd0);
        rst = 0;
        stall = 0;
        // Misaligned jal target faults and halts.
        wait_valid(0);
        step(1, 0, 0, 0, 32'h10, 0);
        check("pre_fault_pc", o_pc[0], 32'h10);
        jal = 1; imm32 = 32'h6;
        @(negedge clk);
        jal = 0; imm32 = 0;
        repeat (4) begin
            check("fault_set", {31'd0, o_flt[0]}, 32'd1);
            check("fault_pc", o_pc[0], 32'h10);
            check("fault_valid", {31'd0, o_vld[0]}, 32'd0);
            @(negedge clk);
        end
        // Sequential run again on both units: 3 vs 5 cycles per instruction.
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        t0 = 0; t1 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (o_vld[0] && t0 == 0) t0 = c;
            if (o_vld[1] && t1 == 0) t1 = c;
            if (t0 != 0 && t1 != 0) break;
            @(negedge clk);
        end
        check("first_valid_lat1", t0, 3);
        check("first_valid_lat3", t1, 5);
        for (int k = 1; k < 4; k++) begin
            next_exec(1, n);
            check("seq_cycles_lat3", n, 5);
            check("seq_pc_lat3", o_pc[1], 32'(4 * k));
            check("seq_inst_lat3", o_inst[1], rom_word(14'(k)));
        end
        // Randomized traffic, including resets at arbitrary points.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0) || (o_flt[0] && o_flt[1]);
            stall = ($urandom_range(0, 3) == 0);
            jalr = ($urandom_range(0, 7) == 0);
            jal = ($urandom_range(0, 7) == 0);
            branch = ($urandom_range(0, 3) == 0);
            zero = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 15) == 0) imm32 = 32'h6;
            else imm32 = 32'((int'($urandom_range(0, 511)) - 256) * 4);
            alu_result = $urandom();
            if ($urandom_range(0, 3) != 0) alu_result[1] = 1'b0;
            @(negedge clk);
        end
        rst = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
